// File: rtl/huffman_decoder.sv
// Bit-serial JPEG baseline Huffman decoder for the standard luminance tables
// (DC: T.81 Table K.3, AC: T.81 Table K.5). One code bit is shifted in per
// qualified cycle; on a complete codeword the (RUN, SIZE) pair is registered
// and a one-cycle done pulse is raised.
module huffman_decoder #(
  parameter int MAX_LEN = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ac_dc_flag,
  input  logic       next_bit,
  input  logic       is_new,
  output logic [3:0] r_value,
  output logic [3:0] s_value,
  output logic       done
);

  localparam int LW     = $clog2(MAX_LEN + 1);
  localparam int AC_NUM = 162;

  // Number of codes of each length (BITS list) for the two tables.
  function automatic int bits_f(input bit dc, input int l);
    bits_f = 0;
    if (dc) begin
      case (l)
        2:                  bits_f = 1;
        3:                  bits_f = 5;
        4, 5, 6, 7, 8, 9:   bits_f = 1;
        default:            bits_f = 0;
      endcase
    end else begin
      case (l)
        2:       bits_f = 2;
        3:       bits_f = 1;
        4, 5:    bits_f = 3;
        6:       bits_f = 2;
        7:       bits_f = 4;
        8:       bits_f = 3;
        9, 10:   bits_f = 5;
        11, 12:  bits_f = 4;
        15:      bits_f = 1;
        16:      bits_f = 125;
        default: bits_f = 0;
      endcase
    end
  endfunction

  // Smallest canonical code of length l (MINCODE).
  function automatic int mincode_f(input bit dc, input int l);
    int code;
    code = 0;
    for (int i = 1; i < l; i++) code = (code + bits_f(dc, i)) << 1;
    mincode_f = code;
  endfunction

  // Index of the first HUFFVAL entry with code length l (VALPTR).
  function automatic int valptr_f(input bit dc, input int l);
    int sum;
    sum = 0;
    for (int i = 1; i < l; i++) sum = sum + bits_f(dc, i);
    valptr_f = sum;
  endfunction

  // AC HUFFVAL list in code order; high nibble is RUN, low nibble is SIZE.
  localparam logic [7:0] AC_VALS [0:AC_NUM-1] = '{
    8'h01, 8'h02, 8'h03, 8'h00, 8'h04, 8'h11, 8'h05, 8'h12,
    8'h21, 8'h31, 8'h41, 8'h06, 8'h13, 8'h51, 8'h61, 8'h07,
    8'h22, 8'h71, 8'h14, 8'h32, 8'h81, 8'h91, 8'ha1, 8'h08,
    8'h23, 8'h42, 8'hb1, 8'hc1, 8'h15, 8'h52, 8'hd1, 8'hf0,
    8'h24, 8'h33, 8'h62, 8'h72, 8'h82, 8'h09, 8'h0a, 8'h16,
    8'h17, 8'h18, 8'h19, 8'h1a, 8'h25, 8'h26, 8'h27, 8'h28,
    8'h29, 8'h2a, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
    8'h3a, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48, 8'h49,
    8'h4a, 8'h53, 8'h54, 8'h55, 8'h56, 8'h57, 8'h58, 8'h59,
    8'h5a, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h68, 8'h69,
    8'h6a, 8'h73, 8'h74, 8'h75, 8'h76, 8'h77, 8'h78, 8'h79,
    8'h7a, 8'h83, 8'h84, 8'h85, 8'h86, 8'h87, 8'h88, 8'h89,
    8'h8a, 8'h92, 8'h93, 8'h94, 8'h95, 8'h96, 8'h97, 8'h98,
    8'h99, 8'h9a, 8'ha2, 8'ha3, 8'ha4, 8'ha5, 8'ha6, 8'ha7,
    8'ha8, 8'ha9, 8'haa, 8'hb2, 8'hb3, 8'hb4, 8'hb5, 8'hb6,
    8'hb7, 8'hb8, 8'hb9, 8'hba, 8'hc2, 8'hc3, 8'hc4, 8'hc5,
    8'hc6, 8'hc7, 8'hc8, 8'hc9, 8'hca, 8'hd2, 8'hd3, 8'hd4,
    8'hd5, 8'hd6, 8'hd7, 8'hd8, 8'hd9, 8'hda, 8'he1, 8'he2,
    8'he3, 8'he4, 8'he5, 8'he6, 8'he7, 8'he8, 8'he9, 8'hea,
    8'hf1, 8'hf2, 8'hf3, 8'hf4, 8'hf5, 8'hf6, 8'hf7, 8'hf8,
    8'hf9, 8'hfa
  };

  // A full-length code either matches or is discarded, so only MAX_LEN-1
  // prefix bits ever need to be held.
  logic [MAX_LEN-2:0] code_reg;
  logic [LW-1:0]      len_reg;
  logic               dc_sel_reg;

  logic [MAX_LEN-1:0] code_next;
  logic [LW-1:0]      len_next;
  logic               sel_dc;
  logic [MAX_LEN:1]   hit_dc;
  logic [MAX_LEN:1]   hit_ac;
  logic [7:0]         idx_dc [1:MAX_LEN];
  logic [7:0]         idx_ac [1:MAX_LEN];
  logic               match;
  logic [7:0]         idx;
  logic [7:0]         sym;

  assign code_next = {code_reg, next_bit};
  assign len_next  = len_reg + LW'(1);
  // The table flag only counts on the first bit; later changes are ignored.
  assign sel_dc    = (len_reg == '0) ? ac_dc_flag : dc_sel_reg;

  // Per-length canonical comparators with MINCODE/MAXCODE/VALPTR folded
  // into constants at elaboration time.
  for (genvar gi = 1; gi <= MAX_LEN; gi++) begin : g_len
    localparam int DC_N   = bits_f(1'b1, gi);
    localparam int DC_MIN = mincode_f(1'b1, gi);
    localparam int DC_PTR = valptr_f(1'b1, gi);
    localparam int AC_N   = bits_f(1'b0, gi);
    localparam int AC_MIN = mincode_f(1'b0, gi);
    localparam int AC_PTR = valptr_f(1'b0, gi);

    if (DC_N != 0) begin : g_dc
      assign hit_dc[gi] = (code_next <= MAX_LEN'(DC_MIN + DC_N - 1));
      assign idx_dc[gi] = 8'(DC_PTR) + 8'(code_next - MAX_LEN'(DC_MIN));
    end else begin : g_dc_empty
      assign hit_dc[gi] = 1'b0;
      assign idx_dc[gi] = 8'd0;
    end

    if (AC_N != 0) begin : g_ac
      assign hit_ac[gi] = (code_next <= MAX_LEN'(AC_MIN + AC_N - 1));
      assign idx_ac[gi] = 8'(AC_PTR) + 8'(code_next - MAX_LEN'(AC_MIN));
    end else begin : g_ac_empty
      assign hit_ac[gi] = 1'b0;
      assign idx_ac[gi] = 8'd0;
    end
  end

  // Pick the comparator for the current code length and selected table.
  always_comb begin
    match = 1'b0;
    idx   = 8'd0;
    for (int l = 1; l <= MAX_LEN; l++) begin
      if (len_next == LW'(l)) begin
        if (sel_dc) begin
          match = hit_dc[l];
          idx   = idx_dc[l];
        end else begin
          match = hit_ac[l];
          idx   = idx_ac[l];
        end
      end
    end
  end

  // HUFFVAL lookup: DC values are simply the index (RUN always 0).
  always_comb begin
    sym = 8'd0;
    if (sel_dc) begin
      sym = {4'd0, idx[3:0]};
    end else if (idx < 8'(AC_NUM)) begin
      sym = AC_VALS[idx];
    end
  end

  // Shift register, length counter and registered symbol outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      code_reg   <= '0;
      len_reg    <= '0;
      dc_sel_reg <= 1'b0;
      done       <= 1'b0;
      r_value    <= 4'd0;
      s_value    <= 4'd0;
    end else begin
      done <= 1'b0;
      if (is_new) begin
        if (len_reg == '0) dc_sel_reg <= ac_dc_flag;
        if (match) begin
          r_value  <= sym[7:4];
          s_value  <= sym[3:0];
          done     <= 1'b1;
          code_reg <= '0;
          len_reg  <= '0;
        end else if (len_next == LW'(MAX_LEN)) begin
          // No codeword of maximum length matched: drop the bits silently.
          code_reg <= '0;
          len_reg  <= '0;
        end else begin
          code_reg <= code_next[MAX_LEN-2:0];
          len_reg  <= len_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_huffman_decoder.sv
// Directed bench for huffman_decoder: walks through reset, DC/AC codewords,
// back-to-back codes, gaps, table-flag changes, invalid codes and mid-code reset.
module tb_huffman_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ac_dc_flag = 1'b0;
  logic       next_bit = 1'b0;
  logic       is_new = 1'b0;
  logic [3:0] r_value;
  logic [3:0] s_value;
  logic       done;

  int checks = 0;
  int failures = 0;

  huffman_decoder dut (
    .clk        (clk),
    .rst        (rst),
    .ac_dc_flag (ac_dc_flag),
    .next_bit   (next_bit),
    .is_new     (is_new),
    .r_value    (r_value),
    .s_value    (s_value),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Hard stop if the sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply inputs for one cycle and return at the following negedge.
  task automatic drive(input logic v, input logic b, input logic f);
    is_new     = v;
    next_bit   = b;
    ac_dc_flag = f;
    @(negedge clk);
  endtask

  // Shift a code string in, MSB first; done must stay low before the last bit.
  task automatic send_code(input string tag, input string bits,
                           input logic f_first, input logic f_rest);
    for (int i = 0; i < bits.len(); i++) begin
      drive(1'b1, bits[i] == "1", (i == 0) ? f_first : f_rest);
      if (i < bits.len() - 1) chk({tag, "_nodone"}, 8'(done), 8'd0);
    end
    is_new = 1'b0;
  endtask

  task automatic chk_sym(input string tag, input logic [3:0] r, input logic [3:0] s);
    chk({tag, "_done"}, 8'(done), 8'd1);
    chk({tag, "_r"}, 8'(r_value), 8'(r));
    chk({tag, "_s"}, 8'(s_value), 8'(s));
    $display("txn %s r=%0d s=%0d done=%0b", tag, r_value, s_value, done);
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    chk("reset_done", 8'(done), 8'd0);
    chk("reset_r", 8'(r_value), 8'd0);
    chk("reset_s", 8'(s_value), 8'd0);
    $display("txn reset r=%0d s=%0d done=%0b", r_value, s_value, done);
    rst = 1'b0;

    // DC 011 -> category 2, then AC 11011 -> 0x12 with no gap.
    send_code("dc_011", "011", 1'b1, 1'b1);
    chk_sym("dc_011", 4'd0, 4'd2);
    send_code("ac_11011", "11011", 1'b0, 1'b0);
    chk_sym("ac_11011", 4'd1, 4'd2);

    // Idle: pulse ends, outputs hold.
    drive(1'b0, 1'b1, 1'b1);
    chk("idle_done", 8'(done), 8'd0);
    chk("idle_hold", {r_value, s_value}, 8'h12);

    send_code("dc_00", "00", 1'b1, 1'b1);
    chk_sym("dc_00", 4'd0, 4'd0);
    send_code("dc_len9", "111111110", 1'b1, 1'b1);
    chk_sym("dc_len9", 4'd0, 4'd11);
    send_code("ac_00", "00", 1'b0, 1'b0);
    chk_sym("ac_00", 4'd0, 4'd1);
    send_code("ac_eob", "1010", 1'b0, 1'b0);
    chk_sym("ac_eob", 4'd0, 4'd0);
    send_code("ac_zrl", "11111111001", 1'b0, 1'b0);
    chk_sym("ac_zrl", 4'd15, 4'd0);
    send_code("ac_fa", "1111111111111110", 1'b0, 1'b0);
    chk_sym("ac_fa", 4'd15, 4'd10);

    // Flag flips to DC after the first bit: still decoded as AC 1100 -> 0x11.
    send_code("ac_flagflip", "1100", 1'b0, 1'b1);
    chk_sym("ac_flagflip", 4'd1, 4'd1);

    // DC 110 with idle gaps (junk on next_bit) -> category 5.
    drive(1'b1, 1'b1, 1'b1);
    chk("gap_b0", 8'(done), 8'd0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b0);
      chk("gap_idle1", 8'(done), 8'd0);
    end
    drive(1'b1, 1'b1, 1'b1);
    chk("gap_b1", 8'(done), 8'd0);
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b1, 1'b0);
      chk("gap_idle2", 8'(done), 8'd0);
    end
    drive(1'b1, 1'b0, 1'b1);
    chk_sym("dc_110_gaps", 4'd0, 4'd5);

    // Sixteen AC ones: invalid, no done, outputs unchanged; decoder restarts cleanly.
    send_code("ac_invalid", "1111111111111111", 1'b0, 1'b0);
    chk("ac_invalid_last", 8'(done), 8'd0);
    chk("ac_invalid_hold", {r_value, s_value}, 8'h05);
    drive(1'b0, 1'b0, 1'b0);
    chk("ac_invalid_after", 8'(done), 8'd0);
    $display("txn ac_invalid r=%0d s=%0d done=%0b", r_value, s_value, done);
    send_code("ac_00_after_inv", "00", 1'b0, 1'b0);
    chk_sym("ac_00_after_inv", 4'd0, 4'd1);

    // Reset after two AC bits discards the partial code.
    send_code("ac_partial", "11", 1'b0, 1'b0);
    chk("partial_nodone", 8'(done), 8'd0);
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    chk("midrst_done", 8'(done), 8'd0);
    chk("midrst_r", 8'(r_value), 8'd0);
    chk("midrst_s", 8'(s_value), 8'd0);
    $display("txn mid_reset r=%0d s=%0d done=%0b", r_value, s_value, done);
    send_code("ac_00_after_rst", "00", 1'b0, 1'b0);
    chk_sym("ac_00_after_rst", 4'd0, 4'd1);
    drive(1'b0, 1'b0, 1'b0);
    chk("final_idle", 8'(done), 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
